move_repeat_ctrl: RTL and testbench

//  Turns debounced direction buttons into rate-limited player-move requests
//  for the maze core, with keyboard-style auto-repeat.

---
 rtl/move_repeat_ctrl.sv | 128 ++++++++++++
 tb/tb_move_repeat_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_repeat_ctrl.sv
// Direction-button front end for the maze core: one move per timer period,
// with keyboard-style auto-repeat and capture of short taps while waiting.
module move_repeat_ctrl #(
  parameter logic [7:0] FIRST_MS    = 8'd250,
  parameter logic [7:0] REPEAT_MS   = 8'd80,
  parameter logic [7:0] FAST_MS     = 8'd40,
  parameter logic [3:0] ACCEL_AFTER = 4'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic       delay_set,
  output logic [7:0] delay_ms,
  input  logic       delay_expired,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, EMIT, ARM, WAIT} state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_btn_q, r_pending, w_pending_nxt;
  logic [3:0] r_rep_cnt, w_rep_cnt_nxt, w_rep_inc;
  logic [1:0] r_last_dir, w_last_dir_nxt;
  logic [1:0] r_move_dir, w_move_dir_nxt;
  logic       r_move_valid, w_move_valid_nxt;
  logic       r_delay_set, w_delay_set_nxt;
  logic [7:0] r_delay_ms, w_delay_ms_nxt, w_period;
  logic       r_first, w_first_nxt;
  logic [3:0] w_rise, w_cand, w_sel_mask;
  logic [1:0] w_sel;
  logic       w_repeat, w_take;

  assign w_rise = btn & ~r_btn_q;
  assign w_cand = btn | r_pending;

  always_comb begin
    w_sel = 2'd3;
    if (w_cand[0])      w_sel = 2'd0;
    else if (w_cand[1]) w_sel = 2'd1;
    else if (w_cand[2]) w_sel = 2'd2;
  end

  assign w_sel_mask = 4'b0001 << w_sel;
  // A press out of IDLE is always a first move: nothing was held across it.
  assign w_repeat   = (r_state == WAIT) && (w_sel == r_last_dir) &&
                      btn[w_sel] && !r_pending[w_sel];
  assign w_rep_inc  = (r_rep_cnt == 4'hF) ? r_rep_cnt : r_rep_cnt + 4'd1;
  assign w_period   = r_first ? FIRST_MS :
                      (r_rep_cnt >= ACCEL_AFTER) ? FAST_MS : REPEAT_MS;

  always_comb begin
    w_state_nxt      = r_state;
    w_pending_nxt    = r_pending | w_rise;
    w_rep_cnt_nxt    = r_rep_cnt;
    w_last_dir_nxt   = r_last_dir;
    w_move_dir_nxt   = r_move_dir;
    w_move_valid_nxt = r_move_valid;
    w_delay_set_nxt  = 1'b0;
    w_delay_ms_nxt   = r_delay_ms;
    w_first_nxt      = r_first;
    w_take           = 1'b0;
    case (r_state)
      IDLE: w_take = (w_cand != 4'd0);
      EMIT: begin
        if (r_move_valid && move_ready) begin
          w_move_valid_nxt = 1'b0;
          w_delay_set_nxt  = 1'b1;
          w_delay_ms_nxt   = w_period;
          w_state_nxt      = ARM;
        end
      end
      ARM:  w_state_nxt = WAIT;
      WAIT: begin
        if (delay_expired) begin
          if (w_cand != 4'd0) w_take = 1'b1;
          else                w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_take) begin
      // Rises of other buttons in this same cycle stay pending for later.
      w_pending_nxt    = (r_pending | w_rise) & ~w_sel_mask;
      w_move_dir_nxt   = w_sel;
      w_last_dir_nxt   = w_sel;
      w_move_valid_nxt = 1'b1;
      w_state_nxt      = EMIT;
      w_rep_cnt_nxt    = w_repeat ? w_rep_inc : 4'd0;
      w_first_nxt      = !w_repeat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_btn_q      <= 4'd0;
      r_pending    <= 4'd0;
      r_rep_cnt    <= 4'd0;
      r_last_dir   <= 2'd0;
      r_move_dir   <= 2'd0;
      r_move_valid <= 1'b0;
      r_delay_set  <= 1'b0;
      r_delay_ms   <= 8'd0;
      r_first      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_btn_q      <= btn;
      r_pending    <= w_pending_nxt;
      r_rep_cnt    <= w_rep_cnt_nxt;
      r_last_dir   <= w_last_dir_nxt;
      r_move_dir   <= w_move_dir_nxt;
      r_move_valid <= w_move_valid_nxt;
      r_delay_set  <= w_delay_set_nxt;
      r_delay_ms   <= w_delay_ms_nxt;
      r_first      <= w_first_nxt;
    end
  end

  assign move_valid = r_move_valid;
  assign move_dir   = r_move_dir;
  assign delay_set  = r_delay_set;
  assign delay_ms   = r_delay_ms;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_move_repeat_ctrl.sv
// Bench for move_repeat_ctrl: behavioural delay timer, move scoreboard,
// one task per scenario.
module tb_move_repeat_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'd0;
  logic       move_ready = 1'b0;
  logic       move_valid, delay_set, delay_expired, busy;
  logic [1:0] move_dir;
  logic [7:0] delay_ms;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  move_repeat_ctrl dut (
    .clk(clk), .rst(rst), .btn(btn), .move_ready(move_ready),
    .move_valid(move_valid), .move_dir(move_dir), .delay_set(delay_set),
    .delay_ms(delay_ms), .delay_expired(delay_expired), .busy(busy)
  );

  // Timer model: expires delay_ms cycles after the set, flags a re-set while running
  logic [7:0] t_cnt = 8'd0;
  logic       t_exp = 1'b0;
  bit         t_overlap = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      t_cnt <= 8'd0;
      t_exp <= 1'b0;
    end else begin
      t_exp <= 1'b0;
      if (delay_set) begin
        if (t_cnt != 8'd0) t_overlap <= 1'b1;
        t_cnt <= delay_ms;
      end else if (t_cnt != 8'd0) begin
        t_cnt <= t_cnt - 8'd1;
        if (t_cnt == 8'd1) t_exp <= 1'b1;
      end
    end
  end
  assign delay_expired = t_exp;

  // Scoreboard: accepted direction paired with the period that follows it
  typedef struct packed {logic [1:0] dir; logic [7:0] ms;} mv_t;
  mv_t q_exp[$];
  mv_t q_obs[$];
  logic [1:0] acc_dir = 2'd0;
  always @(posedge clk) if (!rst && move_valid && move_ready) acc_dir <= move_dir;
  always @(negedge clk) if (!rst && delay_set) q_obs.push_back({acc_dir, delay_ms});

  task automatic wait_obs(input int n, output bit to);
    int c = 0;
    while (q_obs.size() < n && c < 3000) begin @(negedge clk); c++; end
    to = (q_obs.size() < n);
  endtask

  task automatic wait_idle(output bit to);
    int c = 0;
    while (busy && c < 3000) begin @(negedge clk); c++; end
    to = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 4'd0; move_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({move_valid, move_dir, delay_set, delay_ms} !== 12'd0)
      $display("FAIL reset_outputs got=%h exp=000", {move_valid, move_dir, delay_set, delay_ms});
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy, move_valid} !== 2'b00) $display("FAIL idle_quiet got=%b exp=00", {busy, move_valid});
    else n_pass++;
  endtask

  task automatic test_tap(input string nm);
    bit to;
    mv_t e, o;
    move_ready = 1'b1;
    btn = 4'b0001;
    q_exp.push_back({2'd0, 8'd250});
    @(negedge clk);
    n_total++;
    if ({move_valid, move_dir} !== 3'b100)
      $display("FAIL %s_latency got=%b exp=100", nm, {move_valid, move_dir});
    else n_pass++;
    repeat (2) @(negedge clk);
    btn = 4'd0;
    wait_idle(to);
    n_total++;
    if (to) $display("FAIL %s_idle busy=%b exp=0", nm, busy); else n_pass++;
    n_total++;
    if (q_obs.size() != q_exp.size())
      $display("FAIL %s_count got=%0d exp=%0d", nm, q_obs.size(), q_exp.size());
    else n_pass++;
    while (q_exp.size() > 0 && q_obs.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); n_total++;
      if (o !== e) $display("FAIL %s_move got=dir%0d/ms%0d exp=dir%0d/ms%0d", nm, o.dir, o.ms, e.dir, e.ms);
      else n_pass++;
    end
    q_exp.delete(); q_obs.delete();
  endtask

  task automatic test_hold();
    bit to;
    mv_t e, o;
    logic [7:0] ms_list [7] = '{8'd250, 8'd80, 8'd80, 8'd80, 8'd40, 8'd40, 8'd40};
    move_ready = 1'b1;
    btn = 4'b1000;
    for (int i = 0; i < 7; i++) q_exp.push_back({2'd3, ms_list[i]});
    wait_obs(7, to);
    btn = 4'd0;
    n_total++;
    if (to) $display("FAIL hold_moves got=%0d exp=7", q_obs.size()); else n_pass++;
    wait_idle(to);
    n_total++;
    if (to) $display("FAIL hold_idle busy=%b exp=0", busy); else n_pass++;
    n_total++;
    if (t_overlap !== 1'b0) $display("FAIL hold_timer_reset got=%b exp=0", t_overlap); else n_pass++;
    n_total++;
    if (q_obs.size() != q_exp.size())
      $display("FAIL hold_count got=%0d exp=%0d", q_obs.size(), q_exp.size());
    else n_pass++;
    while (q_exp.size() > 0 && q_obs.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); n_total++;
      if (o !== e) $display("FAIL hold_move got=dir%0d/ms%0d exp=dir%0d/ms%0d", o.dir, o.ms, e.dir, e.ms);
      else n_pass++;
    end
    q_exp.delete(); q_obs.delete();
  endtask

  task automatic test_backpressure();
    bit to, bad;
    mv_t e, o;
    move_ready = 1'b0;
    btn = 4'b0010;
    @(negedge clk);
    btn = 4'd0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if ({move_valid, move_dir, delay_set} !== 4'b1010) bad = 1'b1;
      @(negedge clk);
    end
    n_total++;
    if (bad) $display("FAIL bp_hold got=%b exp=1010", {move_valid, move_dir, delay_set}); else n_pass++;
    move_ready = 1'b1;
    q_exp.push_back({2'd1, 8'd250});
    @(negedge clk);
    n_total++;
    if ({move_valid, delay_set} !== 2'b01)
      $display("FAIL bp_handshake got=%b exp=01", {move_valid, delay_set});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (delay_set !== 1'b0) $display("FAIL bp_set_width got=%b exp=0", delay_set); else n_pass++;
    wait_idle(to);
    n_total++;
    if (to || q_obs.size() != q_exp.size())
      $display("FAIL bp_count got=%0d exp=%0d", q_obs.size(), q_exp.size());
    else n_pass++;
    while (q_exp.size() > 0 && q_obs.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); n_total++;
      if (o !== e) $display("FAIL bp_move got=dir%0d/ms%0d exp=dir%0d/ms%0d", o.dir, o.ms, e.dir, e.ms);
      else n_pass++;
    end
    q_exp.delete(); q_obs.delete();
  endtask

  task automatic test_tap_in_wait();
    bit to;
    mv_t e, o;
    move_ready = 1'b1;
    btn = 4'b0001;
    @(negedge clk);
    btn = 4'd0;
    q_exp.push_back({2'd0, 8'd250});
    q_exp.push_back({2'd2, 8'd250});
    wait_obs(1, to);
    repeat (5) @(negedge clk);
    btn = 4'b0100;
    repeat (2) @(negedge clk);
    btn = 4'd0;
    wait_idle(to);
    n_total++;
    if (to || q_obs.size() != q_exp.size())
      $display("FAIL tapwait_count got=%0d exp=%0d", q_obs.size(), q_exp.size());
    else n_pass++;
    while (q_exp.size() > 0 && q_obs.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); n_total++;
      if (o !== e) $display("FAIL tapwait_move got=dir%0d/ms%0d exp=dir%0d/ms%0d", o.dir, o.ms, e.dir, e.ms);
      else n_pass++;
    end
    q_exp.delete(); q_obs.delete();
  endtask

  task automatic test_simultaneous();
    bit to;
    mv_t e, o;
    move_ready = 1'b1;
    btn = 4'b1001;
    @(negedge clk);
    btn = 4'd0;
    q_exp.push_back({2'd0, 8'd250});
    q_exp.push_back({2'd3, 8'd250});
    wait_idle(to);
    n_total++;
    if (to || q_obs.size() != q_exp.size())
      $display("FAIL simul_count got=%0d exp=%0d", q_obs.size(), q_exp.size());
    else n_pass++;
    while (q_exp.size() > 0 && q_obs.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); n_total++;
      if (o !== e) $display("FAIL simul_move got=dir%0d/ms%0d exp=dir%0d/ms%0d", o.dir, o.ms, e.dir, e.ms);
      else n_pass++;
    end
    q_exp.delete(); q_obs.delete();
  endtask

  task automatic test_repress_and_change();
    bit to;
    mv_t e, o;
    move_ready = 1'b1;
    // Release and re-press up inside the wait: the re-press is a first move.
    btn = 4'b0001;
    q_exp.push_back({2'd0, 8'd250});
    q_exp.push_back({2'd0, 8'd250});
    q_exp.push_back({2'd0, 8'd80});
    wait_obs(1, to);
    btn = 4'd0;
    repeat (2) @(negedge clk);
    btn = 4'b0001;
    wait_obs(3, to);
    // Switch from up to left while held: left starts over at the first period.
    btn = 4'b0100;
    q_exp.push_back({2'd2, 8'd250});
    q_exp.push_back({2'd2, 8'd80});
    wait_obs(5, to);
    btn = 4'd0;
    wait_idle(to);
    n_total++;
    if (to || q_obs.size() != q_exp.size())
      $display("FAIL repress_count got=%0d exp=%0d", q_obs.size(), q_exp.size());
    else n_pass++;
    while (q_exp.size() > 0 && q_obs.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); n_total++;
      if (o !== e) $display("FAIL repress_move got=dir%0d/ms%0d exp=dir%0d/ms%0d", o.dir, o.ms, e.dir, e.ms);
      else n_pass++;
    end
    q_exp.delete(); q_obs.delete();
  endtask

  task automatic test_reset_mid();
    bit to;
    mv_t e, o;
    move_ready = 1'b0;
    btn = 4'b0001;
    @(negedge clk);
    btn = 4'd0;
    n_total++;
    if (move_valid !== 1'b1) $display("FAIL rstemit_offer got=%b exp=1", move_valid); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if ({move_valid, move_dir, delay_set, delay_ms, busy} !== 13'd0)
      $display("FAIL rstemit_clear got=%h exp=0", {move_valid, move_dir, delay_set, delay_ms, busy});
    else n_pass++;
    rst = 1'b0;
    move_ready = 1'b1;
    btn = 4'b0001;
    @(negedge clk);
    btn = 4'd0;
    q_exp.push_back({2'd0, 8'd250});
    wait_obs(1, to);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if ({move_valid, move_dir, delay_set, delay_ms, busy} !== 13'd0)
      $display("FAIL rstwait_clear got=%h exp=0", {move_valid, move_dir, delay_set, delay_ms, busy});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (q_obs.size() != q_exp.size())
      $display("FAIL rstmid_count got=%0d exp=%0d", q_obs.size(), q_exp.size());
    else n_pass++;
    while (q_exp.size() > 0 && q_obs.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); n_total++;
      if (o !== e) $display("FAIL rstmid_move got=dir%0d/ms%0d exp=dir%0d/ms%0d", o.dir, o.ms, e.dir, e.ms);
      else n_pass++;
    end
    q_exp.delete(); q_obs.delete();
    test_tap("aftrst");
  endtask

  initial begin
    test_reset();
    test_tap("tap");
    test_hold();
    test_backpressure();
    test_tap_in_wait();
    test_simultaneous();
    test_repress_and_change();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
